// File: rtl/vp_fb_update_sched.sv
// Value-predictor feedback scheduler: queues up to two retiring updates per cycle and drains one per
// cycle onto the shared VP table write port, yielding to lookups. Optional macro: VP_FB_COALESCE_EN.
module vp_fb_update_sched #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       fb_i0_valid,
  input  logic [IDX_W-1:0]           fb_i0_idx,
  input  logic                       fb_i0_misp,
  input  logic [2:0]                 fb_i0_useful,
  input  logic                       fb_i1_valid,
  input  logic [IDX_W-1:0]           fb_i1_idx,
  input  logic                       fb_i1_misp,
  input  logic [2:0]                 fb_i1_useful,
  input  logic                       tbl_lookup_busy,
  output logic                       fb_ready,
  output logic                       tbl_wr_en,
  output logic [IDX_W-1:0]           tbl_wr_idx,
  output logic                       tbl_wr_misp,
  output logic [2:0]                 tbl_wr_useful,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             misp;
    logic [2:0]       useful;
  } ent_t;

  // Handshake: feedback slots are offered whenever fb_iN_valid is high. They are accepted on a
  // clock edge where fb_ready is high and dropped (counted in drop_cnt) otherwise; no retry.
  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  ent_t       ent0;
  ent_t       ent1;
  ent_t       first_ent;
  ent_t       second_ent;
  ent_t       head;
  logic [1:0] n_valid;
  logic [1:0] n_new;
  logic [1:0] push_n;
  logic       empty;
  logic       pop;
  logic       tail_merge;
  ent_t       tail_ent;
  logic [PTR_W-1:0] tail_ptr;

  function automatic ent_t merge_ent(input ent_t a, input ent_t b);
    ent_t r;
    r.idx    = a.idx;
    r.misp   = a.misp | b.misp;
    r.useful = (a.useful > b.useful) ? a.useful : b.useful;
    return r;
  endfunction

  assign ent0     = '{idx: fb_i0_idx, misp: fb_i0_misp, useful: fb_i0_useful};
  assign ent1     = '{idx: fb_i1_idx, misp: fb_i1_misp, useful: fb_i1_useful};
  assign n_valid  = {1'b0, fb_i0_valid} + {1'b0, fb_i1_valid};
  assign empty    = (cnt == '0);
  assign pop      = !empty && !tbl_lookup_busy;
  assign head     = mem[rd_ptr];
  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign tail_ent = mem[tail_ptr];
  assign fb_ready = (CNT_W'(DEPTH) - cnt) >= CNT_W'(2);

`ifdef VP_FB_COALESCE_EN
  logic pair_merge;
  assign pair_merge = fb_i0_valid && fb_i1_valid && (fb_i0_idx == fb_i1_idx);

  always_comb begin
    n_new      = pair_merge ? 2'd1 : n_valid;
    first_ent  = pair_merge ? merge_ent(ent0, ent1) : (fb_i0_valid ? ent0 : ent1);
    second_ent = ent1;
    // A lone update folds into the tail unless the tail is also the head leaving this cycle.
    tail_merge = (n_new == 2'd1) && !empty && !((cnt == CNT_W'(1)) && pop) &&
                 (tail_ent.idx == first_ent.idx);
  end
`else
  always_comb begin
    n_new      = n_valid;
    first_ent  = fb_i0_valid ? ent0 : ent1;
    second_ent = ent1;
    tail_merge = 1'b0;
  end
`endif

  assign push_n = (fb_ready && !tail_merge) ? n_new : 2'd0;

  assign tbl_wr_en     = pop;
  assign tbl_wr_idx    = empty ? '0 : head.idx;
  assign tbl_wr_misp   = empty ? 1'b0 : head.misp;
  assign tbl_wr_useful = empty ? 3'd0 : head.useful;
  assign fifo_cnt      = cnt;

  always_ff @(posedge clk) begin
    if (fb_ready) begin
      if (tail_merge) begin
        mem[tail_ptr] <= merge_ent(tail_ent, first_ent);
      end else begin
        if (n_new != 2'd0) mem[wr_ptr] <= first_ent;
        if (n_new == 2'd2) mem[wr_ptr + PTR_W'(1)] <= second_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_n) - CNT_W'(pop);
      if (!fb_ready) begin
        if (({1'b0, drop_cnt} + 17'(n_valid)) > 17'h0FFFF) drop_cnt <= 16'hFFFF;
        else drop_cnt <= drop_cnt + 16'(n_valid);
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_l)
    (push_n != 2'd0) |-> (cnt <= CNT_W'(DEPTH - 2)));
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_l) cnt <= CNT_W'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_l) pop |-> !empty);
`endif

endmodule

// File: tb/tb_vp_fb_update_sched.sv
// Randomized bench for vp_fb_update_sched with a queue-based reference model and directed
// literal checks for reset, backpressure, i1-only, pair handling, drop saturation and mid-run reset.
module tb_vp_fb_update_sched;
  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = IDX_W + 4;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             fb_i0_valid = 1'b0, fb_i1_valid = 1'b0;
  logic [IDX_W-1:0] fb_i0_idx = '0, fb_i1_idx = '0;
  logic             fb_i0_misp = 1'b0, fb_i1_misp = 1'b0;
  logic [2:0]       fb_i0_useful = '0, fb_i1_useful = '0;
  logic             tbl_lookup_busy = 1'b0;
  logic             fb_ready, tbl_wr_en, tbl_wr_misp;
  logic [IDX_W-1:0] tbl_wr_idx;
  logic [2:0]       tbl_wr_useful;
  logic [CNT_W-1:0] fifo_cnt;
  logic [15:0]      drop_cnt;

  vp_fb_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .fb_i0_valid(fb_i0_valid), .fb_i0_idx(fb_i0_idx), .fb_i0_misp(fb_i0_misp),
    .fb_i0_useful(fb_i0_useful),
    .fb_i1_valid(fb_i1_valid), .fb_i1_idx(fb_i1_idx), .fb_i1_misp(fb_i1_misp),
    .fb_i1_useful(fb_i1_useful),
    .tbl_lookup_busy(tbl_lookup_busy), .fb_ready(fb_ready), .tbl_wr_en(tbl_wr_en),
    .tbl_wr_idx(tbl_wr_idx), .tbl_wr_misp(tbl_wr_misp), .tbl_wr_useful(tbl_wr_useful),
    .fifo_cnt(fifo_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queued entries {idx, misp, useful} and a saturating drop total.
  logic [EW-1:0] exp_q[$];
  int            drop_m = 0;
  logic [EW-1:0] m_new[$];
  logic [EW-1:0] m_e0, m_e1;
  int            m_sz;
  bit            m_rdy, m_pop, m_tail;

  function automatic logic [EW-1:0] mrg(input logic [EW-1:0] a, input logic [EW-1:0] b);
    logic [2:0] u;
    u = (a[2:0] > b[2:0]) ? a[2:0] : b[2:0];
    return {a[EW-1:4], a[3] | b[3], u};
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      exp_q.delete();
      drop_m = 0;
    end else begin
      m_sz  = exp_q.size();
      m_rdy = (DEPTH - m_sz) >= 2;
      m_pop = (m_sz > 0) && !tbl_lookup_busy;
      m_e0  = {fb_i0_idx, fb_i0_misp, fb_i0_useful};
      m_e1  = {fb_i1_idx, fb_i1_misp, fb_i1_useful};
      m_new.delete();
      if (fb_i0_valid) m_new.push_back(m_e0);
      if (fb_i1_valid) m_new.push_back(m_e1);
`ifdef VP_FB_COALESCE_EN
      if (m_new.size() == 2 && fb_i0_idx == fb_i1_idx) begin
        m_new.delete();
        m_new.push_back(mrg(m_e0, m_e1));
      end
      m_tail = (m_new.size() == 1) && (m_sz > 0) && !(m_sz == 1 && m_pop) &&
               (exp_q[m_sz-1][EW-1:4] == m_new[0][EW-1:4]);
`else
      m_tail = 1'b0;
`endif
      if (!m_rdy) begin
        drop_m = drop_m + int'(fb_i0_valid) + int'(fb_i1_valid);
        if (drop_m > 65535) drop_m = 65535;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_rdy) begin
        if (m_tail) exp_q[exp_q.size()-1] = mrg(exp_q[exp_q.size()-1], m_new[0]);
        else foreach (m_new[k]) exp_q.push_back(m_new[k]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  // Compare process: every cycle out of reset, the DUT must agree with the model.
  always @(negedge clk) begin
    if (rst_l) begin
      chk("cnt", 32'(fifo_cnt), 32'(exp_q.size()));
      chk("ready", 32'(fb_ready), 32'((DEPTH - exp_q.size()) >= 2));
      chk("drop", 32'(drop_cnt), 32'(drop_m));
      chk("wr_en", 32'(tbl_wr_en), 32'((exp_q.size() > 0) && !tbl_lookup_busy));
      if (exp_q.size() > 0)
        chk("head", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}), 32'(exp_q[0]));
      else
        chk("empty_out", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v0, input logic [IDX_W-1:0] x0, input bit m0, input logic [2:0] u0,
                     input bit v1, input logic [IDX_W-1:0] x1, input bit m1, input logic [2:0] u1,
                     input bit b);
    fb_i0_valid = v0; fb_i0_idx = x0; fb_i0_misp = m0; fb_i0_useful = u0;
    fb_i1_valid = v1; fb_i1_idx = x1; fb_i1_misp = m1; fb_i1_useful = u1;
    tbl_lookup_busy = b;
  endtask

  task automatic idle(input bit b);
    drv(0, '0, 0, 3'd0, 0, '0, 0, 3'd0, b);
  endtask

  initial begin
    idle(0);
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;

    // Single i0 update written the next cycle.
    drv(1, 8'h12, 1, 3'd3, 0, '0, 0, 3'd0, 0);
    #1;
    chk("rst_cnt", 32'(fifo_cnt), 0);
    chk("rst_ready", 32'(fb_ready), 1);
    chk("rst_wr_en", 32'(tbl_wr_en), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    tick(); idle(0); #1;
    chk("t1_wr_en", 32'(tbl_wr_en), 1);
    chk("t1_idx", 32'(tbl_wr_idx), 32'h12);
    chk("t1_misp", 32'(tbl_wr_misp), 1);
    chk("t1_useful", 32'(tbl_wr_useful), 3);
    chk("t1_cnt", 32'(fifo_cnt), 1);
    tick(); #1;
    chk("t1_cnt_after", 32'(fifo_cnt), 0);

    // Lookup holds the port: fill, overflow, then drain in order.
    drv(1, 8'h40, 0, 3'd0, 1, 8'h41, 1, 3'd1, 1); tick();
    drv(1, 8'h42, 0, 3'd2, 1, 8'h43, 1, 3'd3, 1); tick();
    drv(1, 8'h44, 0, 3'd4, 1, 8'h45, 1, 3'd5, 1); #1;
    chk("t2_cnt", 32'(fifo_cnt), 4);
    chk("t2_ready", 32'(fb_ready), 0);
    chk("t2_wr_en", 32'(tbl_wr_en), 0);
    tick(); idle(1); #1;
    chk("t2_drop", 32'(drop_cnt), 2);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      idle(0); #1;
      chk("t2_wr_en_drain", 32'(tbl_wr_en), 1);
      chk("t2_order", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}),
          32'({8'h40 + 8'(i), i[0], 3'(i)}));
      tick();
    end
    #1 chk("t2_cnt_end", 32'(fifo_cnt), 0);

    // i1-only occupies one entry; i0 fields are ignored.
    drv(0, 8'h77, 1, 3'd7, 1, 8'h05, 0, 3'd2, 0); tick(); idle(0); #1;
    chk("t3_wr_en", 32'(tbl_wr_en), 1);
    chk("t3_head", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}), 32'({8'h05, 1'b0, 3'd2}));
    chk("t3_cnt", 32'(fifo_cnt), 1);
    tick();

    // Same-index pair.
    drv(1, 8'h30, 0, 3'd2, 1, 8'h30, 1, 3'd5, 0); tick(); idle(0); #1;
`ifdef VP_FB_COALESCE_EN
    chk("t4_cnt", 32'(fifo_cnt), 1);
    chk("t4_head", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}), 32'({8'h30, 1'b1, 3'd5}));
    tick();
`else
    chk("t4_cnt", 32'(fifo_cnt), 2);
    chk("t4_head0", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}), 32'({8'h30, 1'b0, 3'd2}));
    tick(); #1;
    chk("t4_head1", 32'({tbl_wr_idx, tbl_wr_misp, tbl_wr_useful}), 32'({8'h30, 1'b1, 3'd5}));
    tick();
`endif
    #1 chk("t4_cnt_end", 32'(fifo_cnt), 0);

    // Randomized traffic; a narrow index range makes index collisions frequent.
    repeat (3000) begin
      drv(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), $urandom_range(0, 9) < 4);
      tick();
    end

    idle(0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("drain_bound", 32'(exp_q.size()), 0);

    // Drop counter saturation.
    drv(1, 8'h10, 0, 3'd1, 1, 8'h11, 0, 3'd1, 1); tick();
    drv(1, 8'h12, 0, 3'd1, 1, 8'h13, 0, 3'd1, 1); tick();
    for (int i = 0; i < 40000 && drop_m < 65533; i++) tick();
    drv(1, 8'h14, 0, 3'd1, 0, '0, 0, 3'd0, 1);
    for (int i = 0; i < 4 && drop_m < 65534; i++) tick();
    #1 chk("t5_pre", 32'(drop_cnt), 32'hFFFE);
    drv(1, 8'h14, 0, 3'd1, 1, 8'h15, 0, 3'd1, 1); tick(); #1;
    chk("t5_sat", 32'(drop_cnt), 32'hFFFF);
    tick(); #1;
    chk("t5_hold", 32'(drop_cnt), 32'hFFFF);

    // Reset in the middle of a drain.
    idle(0); tick(); #1;
    chk("t6_pre_cnt", 32'(fifo_cnt), 3);
    chk("t6_pre_wr_en", 32'(tbl_wr_en), 1);
    rst_l = 1'b0; #1;
    chk("t6_wr_en", 32'(tbl_wr_en), 0);
    chk("t6_cnt", 32'(fifo_cnt), 0);
    chk("t6_ready", 32'(fb_ready), 1);
    chk("t6_drop", 32'(drop_cnt), 0);
    tick();
    rst_l = 1'b1;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
